// File: rtl/jk_seq_pkg.sv
// Shared opcodes, FSM state encoding and the counting toggle-mask helper
// for the JK bank sequencer.
package jk_seq_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;
  localparam logic [2:0] OP_CNT_UP = 3'd5;
  localparam logic [2:0] OP_CNT_DN = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  // Widest bank the mask helper supports.
  localparam int MASK_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit idx toggles when every lower bit equals the direction bit:
  // all ones for counting up, all zeros for counting down.
  function automatic logic count_toggle(input logic [MASK_W-1:0] qv,
                                        input int idx,
                                        input logic up);
    logic t;
    t = 1'b1;
    for (int b = 0; b < MASK_W; b++) begin
      if (b < idx && qv[b] != up) t = 1'b0;
    end
    return t;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell; {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command sequencer driving a WIDTH-bit bank of JK cells.
// Optional build macro JK_SAT_EN makes count commands saturate instead of wrapping.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] j, k, cnt_mask;
  logic             accept, is_count;

  assign accept   = cmd_valid && cmd_ready;
  assign is_count = (cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= OP_NOP;
      data_r <= '0;
      cnt_r  <= '0;
    end else if (accept) begin
      op_r   <= cmd_op;
      data_r <= cmd_data;
      cnt_r  <= cmd_cnt;
    end else if (state == COUNT) begin
      cnt_r  <= cnt_r - CNT_W'(1);
    end
  end

  // Mask follows the live bank value so every step sees the previous step's result.
  always_comb begin
    cnt_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_mask[i] = count_toggle(MASK_W'(q), i, op_r == OP_CNT_UP);
    end
`ifdef JK_SAT_EN
    if ((op_r == OP_CNT_UP && (&q)) || (op_r == OP_CNT_DN && ~(|q))) cnt_mask = '0;
`endif
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    j         = '0;
    k         = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!is_count)             state_nxt = APPLY;
          else if (cmd_cnt != '0)    state_nxt = COUNT;
          else                       state_nxt = DONE;
        end
      end
      APPLY: begin
        busy      = 1'b1;
        state_nxt = DONE;
        case (op_r)
          OP_CLEAR:  k = '1;
          OP_SET:    j = '1;
          OP_TOGGLE: begin j = data_r; k = data_r;  end
          OP_LOAD:   begin j = data_r; k = ~data_r; end
          default:   ;
        endcase
      end
      COUNT: begin
        busy = 1'b1;
        j    = cnt_mask;
        k    = cnt_mask;
        if (cnt_r == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q[g])
    );
  end

endmodule
